// File: rtl/branch_score_unit_pkg.sv
// Shared types and helpers for the branch score unit.
package branch_score_unit_pkg;

  // Helpers do their arithmetic at this fixed width. Callers extend their
  // value on the way in and truncate it on the way out.
  localparam int SAT_W = 64;

  typedef enum logic {IDLE, SWEEP} clr_state_t;
  typedef enum logic {R_IDLE, R_LAT} rd_state_t;

  // The prediction is bit 1 of the predictor state; bit 0 is hysteresis only.
  function automatic logic is_miss(input logic [1:0] predict, input logic outcome);
    return predict[1] != outcome;
  endfunction

  // Adds one to val and holds at 2**width-1 instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input int unsigned width);
    logic [SAT_W-1:0] max_val;
    max_val = (SAT_W'(1) << width) - SAT_W'(1);
    return (val >= max_val) ? val : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/branch_score_unit_score_table.sv
// Per-branch event/miss counter table. It has one saturating increment port,
// one clear port that zeroes a single entry, and a combinational read port.
module branch_score_unit_score_table
  import branch_score_unit_pkg::*;
#(
  parameter int ID_W  = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [ID_W-1:0]  wr_idx,
  input  logic             wr_miss,
  input  logic             clr_en,
  input  logic [ID_W-1:0]  clr_idx,
  input  logic [ID_W-1:0]  rd_idx,
  output logic [CNT_W-1:0] rd_events,
  output logic [CNT_W-1:0] rd_misses
);

  localparam int DEPTH = 2**ID_W;

  logic [CNT_W-1:0] ev_q [DEPTH];
  logic [CNT_W-1:0] ms_q [DEPTH];

  // Entry update: a clear beats a write to the same entry (the two never
  // coincide while the top blocks events during a sweep).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ev_q[i] <= '0;
        ms_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_en && clr_idx == ID_W'(i)) begin
          ev_q[i] <= '0;
          ms_q[i] <= '0;
        end else if (wr_en && wr_idx == ID_W'(i)) begin
          ev_q[i] <= CNT_W'(sat_inc(SAT_W'(ev_q[i]), CNT_W));
          if (wr_miss) begin
            ms_q[i] <= CNT_W'(sat_inc(SAT_W'(ms_q[i]), CNT_W));
          end
        end
      end
    end
  end

  assign rd_events = ev_q[rd_idx];
  assign rd_misses = ms_q[rd_idx];

endmodule

// File: rtl/branch_score_unit.sv
// Branch score unit: global and per-branch prediction statistics, with a
// sequenced table clear and a two-edge handshaked per-branch readout.
module branch_score_unit
  import branch_score_unit_pkg::*;
#(
  parameter int ID_W  = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_valid,
  input  logic [ID_W-1:0]  ev_branch,
  input  logic [1:0]       ev_predict,
  input  logic             ev_outcome,
  input  logic             clr_req,
  input  logic             rd_req,
  input  logic [ID_W-1:0]  rd_branch,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_events,
  output logic [CNT_W-1:0] rd_misses,
  output logic [CNT_W-1:0] tot_events,
  output logic [CNT_W-1:0] tot_misses,
  output logic [CNT_W-1:0] dropped,
  output logic             busy
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(2**ID_W - 1);

  clr_state_t       clr_state, clr_next;
  rd_state_t        rd_state, rd_next;
  logic [ID_W-1:0]  sweep_idx;
  logic [ID_W-1:0]  rd_idx_q;
  logic             ev_miss, ev_accept, ev_drop, sweep_done, rd_accept;
  logic [CNT_W-1:0] tbl_events, tbl_misses;

  assign ev_miss    = is_miss(ev_predict, ev_outcome);
  assign ev_accept  = ev_valid && !busy;
  assign ev_drop    = ev_valid && busy;
  assign sweep_done = (clr_state == SWEEP) && (sweep_idx == LAST_IDX);
  // When idle, clr_req takes priority over a read requested in the same cycle.
  assign rd_accept  = rd_req && rd_ready && !busy && !clr_req;

  // Clear FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) clr_state <= IDLE;
    else        clr_state <= clr_next;
  end

  // Clear FSM next state: one table entry per cycle, then back to idle.
  always_comb begin
    clr_next = clr_state;
    case (clr_state)
      IDLE:    if (clr_req) clr_next = SWEEP;
      SWEEP:   if (sweep_done) clr_next = IDLE;
      default: clr_next = IDLE;
    endcase
  end

  // Clear FSM outputs.
  always_comb begin
    busy = (clr_state == SWEEP);
  end

  // Sweep pointer: starts at 0 and returns to 0 after the last entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  sweep_idx <= '0;
    else if (clr_state == SWEEP) sweep_idx <= sweep_idx + ID_W'(1);
  end

  // Global counters. They are zeroed on the last sweep edge. Events that
  // arrive during a sweep are only counted in dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tot_events <= '0;
      tot_misses <= '0;
      dropped    <= '0;
    end else if (sweep_done) begin
      tot_events <= '0;
      tot_misses <= '0;
      dropped    <= '0;
    end else begin
      if (ev_accept) begin
        tot_events <= CNT_W'(sat_inc(SAT_W'(tot_events), CNT_W));
        if (ev_miss) tot_misses <= CNT_W'(sat_inc(SAT_W'(tot_misses), CNT_W));
      end
      if (ev_drop) dropped <= CNT_W'(sat_inc(SAT_W'(dropped), CNT_W));
    end
  end

  branch_score_unit_score_table #(
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (ev_accept),
    .wr_idx    (ev_branch),
    .wr_miss   (ev_miss),
    .clr_en    (busy),
    .clr_idx   (sweep_idx),
    .rd_idx    (rd_idx_q),
    .rd_events (tbl_events),
    .rd_misses (tbl_misses)
  );

  // Readout FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  // Readout FSM next state: always exactly one cycle in R_LAT.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (rd_accept) rd_next = R_LAT;
      R_LAT:   rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Readout FSM outputs.
  always_comb begin
    rd_ready = (rd_state == R_IDLE);
  end

  // Readout datapath. The entry is sampled on the R_LAT edge, so it includes
  // an event written on the request edge but not one written on this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx_q  <= '0;
      rd_valid  <= 1'b0;
      rd_events <= '0;
      rd_misses <= '0;
    end else begin
      if (rd_accept) rd_idx_q <= rd_branch;
      rd_valid <= (rd_state == R_LAT);
      if (rd_state == R_LAT) begin
        rd_events <= tbl_events;
        rd_misses <= tbl_misses;
      end
    end
  end

endmodule

// File: tb/tb_branch_score_unit.sv
// Self-checking bench for branch_score_unit (ID_W=2, CNT_W=4 so saturation is reachable).
module tb_branch_score_unit;

  localparam int ID_W  = 2;
  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             ev_valid;
  logic [ID_W-1:0]  ev_branch;
  logic [1:0]       ev_predict;
  logic             ev_outcome;
  logic             clr_req;
  logic             rd_req;
  logic [ID_W-1:0]  rd_branch;
  logic             rd_ready;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_events;
  logic [CNT_W-1:0] rd_misses;
  logic [CNT_W-1:0] tot_events;
  logic [CNT_W-1:0] tot_misses;
  logic [CNT_W-1:0] dropped;
  logic             busy;

  branch_score_unit #(.ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ev_valid   (ev_valid),
    .ev_branch  (ev_branch),
    .ev_predict (ev_predict),
    .ev_outcome (ev_outcome),
    .clr_req    (clr_req),
    .rd_req     (rd_req),
    .rd_branch  (rd_branch),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_events  (rd_events),
    .rd_misses  (rd_misses),
    .tot_events (tot_events),
    .tot_misses (tot_misses),
    .dropped    (dropped),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] br;
    logic [1:0] pred;
    logic       outc;
    int         exp_ev;
    int         exp_ms;
  } vec_t;

  typedef struct {
    int br;
    int ev;
    int ms;
  } rd_exp_t;

  int      total = 0;
  int      bad = 0;
  int      rv_seen = 0;
  int      m_ev [DEPTH];
  int      m_ms [DEPTH];
  rd_exp_t sb_q [$];
  vec_t    vecs [7];

  always @(negedge clk) if (reset && rd_valid) rv_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_ev[i] = 0;
      m_ms[i] = 0;
    end
  endtask

  task automatic model_ev(input int br, input logic [1:0] p, input logic o);
    if (m_ev[br] < CMAX) m_ev[br]++;
    if (p[1] != o && m_ms[br] < CMAX) m_ms[br]++;
  endtask

  task automatic push_exp(input int br);
    rd_exp_t e;
    e.br = br;
    e.ev = m_ev[br];
    e.ms = m_ms[br];
    sb_q.push_back(e);
  endtask

  task automatic send_ev(input int br, input logic [1:0] p, input logic o);
    ev_valid   = 1'b1;
    ev_branch  = ID_W'(br);
    ev_predict = p;
    ev_outcome = o;
    step();
    ev_valid = 1'b0;
    model_ev(br, p, o);
  endtask

  // Called one cycle after the request edge (the R_LAT cycle).
  task automatic wait_rd();
    int      lat;
    rd_exp_t e;
    lat = 1;
    chk("rd_ready_in_lat", int'(rd_ready), 0);
    while (!rd_valid && lat < 6) begin
      step();
      ev_valid = 1'b0;
      lat++;
    end
    ev_valid = 1'b0;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL rd_scoreboard: got rd_valid with no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if (!rd_valid) begin
        total++;
        bad++;
        $display("FAIL rd_timeout: got no rd_valid after %0d cycles, expected it after 2", lat);
      end else begin
        chk("rd_latency", lat, 2);
        chk($sformatf("rd_events[%0d]", e.br), int'(rd_events), e.ev);
        chk($sformatf("rd_misses[%0d]", e.br), int'(rd_misses), e.ms);
        step();
        chk("rd_valid_pulse", int'(rd_valid), 0);
        chk("rd_events_hold", int'(rd_events), e.ev);
      end
    end
  endtask

  task automatic read_entry(input int br);
    rd_req    = 1'b1;
    rd_branch = ID_W'(br);
    push_exp(br);
    step();
    rd_req = 1'b0;
    wait_rd();
  endtask

  initial begin
    int busy_cnt;
    int rv0;

    vecs[0] = '{2'd1, 2'b11, 1'b1, 1, 0};
    vecs[1] = '{2'd1, 2'b00, 1'b1, 2, 1};
    vecs[2] = '{2'd1, 2'b10, 1'b0, 3, 2};
    vecs[3] = '{2'd0, 2'b01, 1'b0, 4, 2};
    vecs[4] = '{2'd2, 2'b10, 1'b1, 5, 2};
    vecs[5] = '{2'd3, 2'b11, 1'b0, 6, 3};
    vecs[6] = '{2'd2, 2'b00, 1'b1, 7, 4};

    reset = 1'b0;
    ev_valid = 1'b0; ev_branch = '0; ev_predict = '0; ev_outcome = 1'b0;
    clr_req = 1'b0; rd_req = 1'b0; rd_branch = '0;
    model_clear();
    step();
    step();
    reset = 1'b1;
    step();

    chk("rst_tot_events", int'(tot_events), 0);
    chk("rst_rd_ready", int'(rd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);

    // Make every counter nonzero, then reset asynchronously in mid-sweep.
    send_ev(3, 2'b10, 1'b0);
    send_ev(3, 2'b01, 1'b1);
    read_entry(3);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    ev_valid = 1'b1; ev_branch = 2'd0;
    step();
    ev_valid = 1'b0;
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_dropped", int'(dropped), 1);
    chk("pre_rst_tot_events", int'(tot_events), 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_tot_events", int'(tot_events), 0);
    chk("arst_tot_misses", int'(tot_misses), 0);
    chk("arst_dropped", int'(dropped), 0);
    chk("arst_rd_events", int'(rd_events), 0);
    chk("arst_rd_misses", int'(rd_misses), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rd_ready", int'(rd_ready), 1);
    chk("arst_rd_valid", int'(rd_valid), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
    step();

    // Table-driven back-to-back events, globals checked one edge later.
    for (int i = 0; i < 7; i++) begin
      ev_valid   = 1'b1;
      ev_branch  = vecs[i].br;
      ev_predict = vecs[i].pred;
      ev_outcome = vecs[i].outc;
      step();
      model_ev(int'(vecs[i].br), vecs[i].pred, vecs[i].outc);
      chk($sformatf("vec%0d_tot_events", i), int'(tot_events), vecs[i].exp_ev);
      chk($sformatf("vec%0d_tot_misses", i), int'(tot_misses), vecs[i].exp_ms);
    end
    ev_valid = 1'b0;
    read_entry(1);
    read_entry(0);
    read_entry(2);
    read_entry(3);

    // Sweep clear with three events arriving during the sweep.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy) busy_cnt++;
      if (k == 3) begin
        chk("sweep_dropped", int'(dropped), 3);
        chk("sweep_tot_frozen", int'(tot_events), 7);
      end
      ev_valid   = (k < 3);
      ev_branch  = 2'd1;
      ev_predict = 2'b11;
      ev_outcome = 1'b0;
      step();
    end
    ev_valid = 1'b0;
    chk("sweep_busy_cycles", busy_cnt, 4);
    chk("post_clr_tot_events", int'(tot_events), 0);
    chk("post_clr_tot_misses", int'(tot_misses), 0);
    chk("post_clr_dropped", int'(dropped), 0);
    chk("post_clr_rd_hold", int'(rd_events), 1);
    model_clear();
    for (int b = 0; b < DEPTH; b++) read_entry(b);
    send_ev(1, 2'b10, 1'b1);
    chk("first_after_clr_events", int'(tot_events), 1);
    chk("first_after_clr_misses", int'(tot_misses), 0);

    // Saturation at 15.
    for (int n = 0; n < 20; n++) send_ev(0, 2'b11, 1'b0);
    chk("sat_tot_events", int'(tot_events), 15);
    chk("sat_tot_misses", int'(tot_misses), 15);
    for (int n = 0; n < 3; n++) send_ev(0, 2'b11, 1'b0);
    chk("sat_hold_events", int'(tot_events), 15);
    chk("sat_hold_misses", int'(tot_misses), 15);
    read_entry(0);
    read_entry(1);

    // Clear and read requested together: clear wins. Read during busy is ignored.
    rv0 = rv_seen;
    clr_req = 1'b1; rd_req = 1'b1; rd_branch = 2'd0;
    step();
    clr_req = 1'b0; rd_req = 1'b0;
    chk("clr_wins_busy", int'(busy), 1);
    chk("clr_wins_rd_ready", int'(rd_ready), 1);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("rd_in_busy_ready", int'(rd_ready), 1);
    repeat (5) step();
    chk("clr_wins_done", int'(busy), 0);
    chk("no_rd_valid_count", rv_seen - rv0, 0);
    chk("clr_wins_tot_events", int'(tot_events), 0);
    model_clear();

    // Event on the request edge is included; event on the R_LAT edge is not.
    ev_valid = 1'b1; ev_branch = 2'd2; ev_predict = 2'b00; ev_outcome = 1'b1;
    rd_req = 1'b1; rd_branch = 2'd2;
    model_ev(2, 2'b00, 1'b1);
    push_exp(2);
    step();
    rd_req = 1'b0;
    ev_predict = 2'b11; ev_outcome = 1'b1;
    wait_rd();
    model_ev(2, 2'b11, 1'b1);
    chk("overlap_tot_events", int'(tot_events), 2);
    chk("overlap_tot_misses", int'(tot_misses), 1);
    read_entry(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
